// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//
// Shares one multi-cycle divider between two requesters. A round-robin
// arbiter picks a requester in IDLE and latches its operands. The FSM then
// pulses div_start for one cycle (ISSUE) and waits for div_done or a timeout
// (WAIT). It returns the result to the granted requester with a one-cycle
// resp_valid pulse (RESP).
//
// Optional feature (macro DIV_SHARE_ZERO_CHECK_EN):
//   When defined, a granted divisor of zero bypasses the divider. The block
//   goes straight from IDLE to RESP with quotient = all ones,
//   remainder = dividend and err = 1. When undefined, a zero divisor is
//   issued to the divider like any other operand.
//
// Parameters
//   DATA_W    operand/result width
//   WAIT_MAX  WAIT cycles allowed before a timeout response
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req[1:0]                      request levels, held until resp_valid
//   dividend0/divisor0            operands of requester 0
//   dividend1/divisor1            operands of requester 1
//   resp_valid[1:0]               one-hot response pulse
//   quotient, remainder, err      shared result buses (held until next RESP)
//   busy                          high whenever the FSM is not in IDLE
//   div_start                     one-cycle start pulse to the divider
//   div_dividend, div_divisor     registered operands to the divider
//   div_done                      divider completion level
//   div_quotient, div_remainder   divider results

module div_share_arbiter #(
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] dividend0,
    input  logic [DATA_W-1:0] divisor0,
    input  logic [DATA_W-1:0] dividend1,
    input  logic [DATA_W-1:0] divisor1,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              err,
    output logic              busy,
    output logic              div_start,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic              err_q, err_d;
    logic              div_start_q, div_start_d;
    logic [DATA_W-1:0] div_dividend_q, div_dividend_d;
    logic [DATA_W-1:0] div_divisor_q, div_divisor_d;

    logic              sel;
    logic [DATA_W-1:0] sel_dividend;
    logic [DATA_W-1:0] sel_divisor;

    function automatic logic [1:0] onehot(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: the pointer breaks ties only when both request.
    always_comb begin
        sel          = (req == 2'b11) ? ptr_q : req[1];
        sel_dividend = sel ? dividend1 : dividend0;
        sel_divisor  = sel ? divisor1  : divisor0;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        cnt_d          = cnt_q;
        resp_valid_d   = 2'b00;
        quotient_d     = quotient_q;
        remainder_d    = remainder_q;
        err_d          = err_q;
        div_start_d    = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d        = sel;
                    ptr_d          = ~sel;
                    div_dividend_d = sel_dividend;
                    div_divisor_d  = sel_divisor;
`ifdef DIV_SHARE_ZERO_CHECK_EN
                    if (sel_divisor == '0) begin
                        state_d      = RESP;
                        resp_valid_d = onehot(sel);
                        quotient_d   = '1;
                        remainder_d  = sel_dividend;
                        err_d        = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        div_start_d = 1'b1;
                    end
`else
                    state_d     = ISSUE;
                    div_start_d = 1'b1;
`endif
                end
            end
            ISSUE: begin
                // div_done still reflects the previous operation here, so it
                // is deliberately ignored until WAIT.
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (div_done) begin
                    state_d      = RESP;
                    resp_valid_d = onehot(grant_q);
                    quotient_d   = div_quotient;
                    remainder_d  = div_remainder;
                    err_d        = 1'b0;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    // This is the WAIT_MAX-th WAIT cycle without done.
                    state_d      = RESP;
                    resp_valid_d = onehot(grant_q);
                    quotient_d   = '0;
                    remainder_d  = '0;
                    err_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            grant_q        <= 1'b0;
            cnt_q          <= '0;
            resp_valid_q   <= 2'b00;
            quotient_q     <= '0;
            remainder_q    <= '0;
            err_q          <= 1'b0;
            div_start_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            cnt_q          <= cnt_d;
            resp_valid_q   <= resp_valid_d;
            quotient_q     <= quotient_d;
            remainder_q    <= remainder_d;
            err_q          <= err_d;
            div_start_q    <= div_start_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);
    assign div_start    = div_start_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Testbench for div_share_arbiter: directed and randomized transactions
// checked against a transaction-level reference model (round-robin pointer,
// integer division, expected latency per transaction).
// Honours DIV_SHARE_ZERO_CHECK_EN in the same way as the design.

module tb_div_share_arbiter;

    localparam int DW = 8;
    localparam int WM = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [DW-1:0] dividend0, divisor0, dividend1, divisor1;
    logic [1:0]    resp_valid;
    logic [DW-1:0] quotient, remainder;
    logic          err, busy, div_start;
    logic [DW-1:0] div_dividend, div_divisor;
    logic          div_done;
    logic [DW-1:0] div_quotient, div_remainder;

    int total = 0;
    int bad   = 0;
    int start_total = 0;
    int resp_total  = 0;

    // Divider model controls
    int lat = 1;
    bit never_done = 1'b0;
    int dcnt;

    // Reference model state
    bit ptr = 1'b0;

    div_share_arbiter #(.DATA_W(DW), .WAIT_MAX(WM)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .dividend0     (dividend0),
        .divisor0      (divisor0),
        .dividend1     (dividend1),
        .divisor1      (divisor1),
        .resp_valid    (resp_valid),
        .quotient      (quotient),
        .remainder     (remainder),
        .err           (err),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Divider model: done rises 'lat' edges after the start edge and stays
    // high until the next start. A zero divisor returns all ones / dividend.
    always @(posedge clk) begin
        if (rst) begin
            div_done      <= 1'b0;
            dcnt          <= 0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_start) begin
            div_done <= 1'b0;
            dcnt     <= lat;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !never_done) begin
                div_done <= 1'b1;
                if (div_divisor == 0) begin
                    div_quotient  <= '1;
                    div_remainder <= div_dividend;
                end else begin
                    div_quotient  <= div_dividend / div_divisor;
                    div_remainder <= div_dividend % div_divisor;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (div_start) start_total++;
        if (resp_valid != 2'b00) resp_total++;
        if (!rst) check("resp_not_both", {31'd0, resp_valid == 2'b11}, 32'd0);
    end

    // One transaction: present req at a negedge while the DUT is idle, wait
    // for the response (bounded), compare against the model, then release.
    task automatic do_op(input logic [1:0] r, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input int l, input bit nd);
        bit            g;
        logic [DW-1:0] a, b, eq, er;
        bit            ee;
        int            ecyc, estarts, cycles, s0;
        bit            got;
        g  = (r == 2'b11) ? ptr : r[1];
        ptr = ~g;
        a  = g ? a1 : a0;
        b  = g ? b1 : b0;
        estarts = 1;
        if (nd) begin
            ecyc = WM + 2; eq = '0; er = '0; ee = 1'b1;
        end else begin
            ecyc = l + 3;  ee = 1'b0;
            eq = (b == 0) ? '1 : a / b;
            er = (b == 0) ? a  : a % b;
        end
`ifdef DIV_SHARE_ZERO_CHECK_EN
        if (b == 0) begin
            ecyc = 1; estarts = 0; eq = '1; er = a; ee = 1'b1;
        end
`endif
        @(negedge clk);
        lat = l; never_done = nd;
        dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1;
        req = r;
        s0 = start_total;
        cycles = 0; got = 1'b0;
        while (!got && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (resp_valid != 2'b00) got = 1'b1;
            if (cycles == 1) begin
                // Operand changes after the grant must not matter.
                dividend0 = DW'($urandom); divisor0 = DW'($urandom);
                dividend1 = DW'($urandom); divisor1 = DW'($urandom);
            end
        end
        check("latency", cycles, ecyc);
        check("resp_valid", {30'd0, resp_valid}, {30'd0, g ? 2'b10 : 2'b01});
        check("quotient", {24'd0, quotient}, {24'd0, eq});
        check("remainder", {24'd0, remainder}, {24'd0, er});
        check("err", {31'd0, err}, {31'd0, ee});
        check("div_dividend", {24'd0, div_dividend}, {24'd0, a});
        check("div_divisor", {24'd0, div_divisor}, {24'd0, b});
        req = 2'b00;
        @(negedge clk);
        check("starts", start_total - s0, estarts);
        @(posedge clk); #1;
        check("resp_one_cycle", {30'd0, resp_valid}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("quotient_hold", {24'd0, quotient}, {24'd0, eq});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, cycles;
        bit g;
        rst = 1'b1; req = 2'b00;
        dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_div_start", {31'd0, div_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_div_dividend", {24'd0, div_dividend}, 32'd0);
        check("rst_div_divisor", {24'd0, div_divisor}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ptr = 1'b0;

        // Single operation 100 / 7
        do_op(2'b01, 8'd100, 8'd7, 8'd0, 8'd1, 2, 1'b0);
        // Done held high from previous op; longer latency must still be honoured
        do_op(2'b10, 8'd3, 8'd1, 8'd200, 8'd9, 4, 1'b0);
        do_op(2'b01, 8'd255, 8'd16, 8'd0, 8'd1, 1, 1'b0);

        // Contention: both held high -> alternating grants
        @(negedge clk);
        lat = 1; never_done = 1'b0;
        dividend0 = 8'd90; divisor0 = 8'd9; dividend1 = 8'd77; divisor1 = 8'd5;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = ptr;
            ptr = ~g;
            cycles = 0;
            do begin
                @(posedge clk); #1;
                cycles++;
            end while (resp_valid == 2'b00 && cycles < 50);
            if (k == 3) req = 2'b00;
            check("rr_grant", {30'd0, resp_valid}, {30'd0, g ? 2'b10 : 2'b01});
            check("rr_quotient", {24'd0, quotient}, g ? 32'd15 : 32'd10);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rr_idle", {31'd0, busy}, 32'd0);

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            do_op(2'($urandom_range(1, 3)), DW'($urandom), DW'($urandom_range(1, 255)),
                  DW'($urandom), DW'($urandom_range(1, 255)), $urandom_range(1, 4), 1'b0);
        end

        // Timeout: divider never completes
        do_op(2'b01, 8'd50, 8'd5, 8'd0, 8'd1, 1, 1'b1);

        // Zero divisor on requester 1
        do_op(2'b10, 8'd0, 8'd1, 8'd55, 8'd0, 2, 1'b0);

        // Reset in the middle of WAIT
        @(negedge clk);
        lat = 1; never_done = 1'b1;
        dividend0 = 8'd40; divisor0 = 8'd4;
        req = 2'b01;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req = 2'b00;
        r0 = resp_total;
        @(posedge clk); #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_resp", {30'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ptr = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_resp", resp_total - r0, 32'd0);
        do_op(2'b10, 8'd0, 8'd1, 8'd123, 8'd10, 2, 1'b0);
        // Pointer was reset to 0, so contention now favours requester 0
        do_op(2'b11, 8'd81, 8'd9, 8'd64, 8'd8, 1, 1'b0);

        s0 = start_total;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, operand/result width for both requesters and the shared divider.
REQ-002 Parameter: WAIT_MAX, default 255, maximum cycles allowed in WAIT before timeout.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  2  per-requester request level; req[i] is held high until resp_valid[i].
REQ-006 dividend0, divisor0  input  DATA_W each  operands of requester 0.
REQ-007 dividend1, divisor1  input  DATA_W each  operands of requester 1.
REQ-008 resp_valid  output  2  one-hot, one-cycle response pulse to the granted requester.
REQ-009 quotient, remainder  output  DATA_W each  shared result buses, valid when any resp_valid bit is high.
REQ-010 err  output  1  error flag, qualified by resp_valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 div_start  output  1  start pulse to the shared divider.
REQ-013 div_dividend, div_divisor  output  DATA_W each  registered operands driven to the divider.
REQ-014 div_done  input  1  divider completion level.
REQ-015 div_quotient, div_remainder  input  DATA_W each  divider results.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req bit is high, the block SHALL select a grant, latch that requester's operands into div_dividend and div_divisor, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester; if both requesters are high, the pointer's requester wins; if one is high, it wins regardless of the pointer.
REQ-019 The pointer SHALL be set to the non-granted requester on every grant.
REQ-020 ISSUE: div_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-021 WAIT: div_done SHALL be sampled only in WAIT, never in ISSUE, because the divider holds done from the previous operation.
REQ-022 WAIT: when div_done=1, the block SHALL register div_quotient and div_remainder into quotient and remainder, set err=0, and go to RESP.
REQ-023 WAIT: a wait counter SHALL clear on entry and increment each WAIT cycle.
REQ-024 WAIT: if the wait counter reaches WAIT_MAX without div_done, the block SHALL go to RESP with err=1 and quotient=remainder=0.
REQ-025 RESP: resp_valid[grant] SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 Results SHALL hold their values until the next RESP.
REQ-027 Minimum latency SHALL be 3 cycles plus the divider's done latency, measured from the req edge sampled in IDLE to resp_valid.
REQ-028 Operand changes after grant SHALL be ignored, because operands are latched in IDLE.
REQ-029 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-030 A req deasserted early, before resp_valid, SHALL NOT abort the operation; the response is still pulsed.
REQ-031 div_start SHALL never be asserted outside ISSUE.
REQ-032 resp_valid SHALL never have both bits set.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL enter IDLE, set pointer=0, and clear the wait counter.
REQ-034 Reset SHALL force resp_valid=0, div_start=0, busy=0, err=0, quotient=0, remainder=0, div_dividend=0 and div_divisor=0.
REQ-035 Reset mid-operation SHALL abandon the in-flight operation with no response; the divider is reset by the same rst.

Configuration
REQ-036 The macro DIV_SHARE_ZERO_CHECK_EN SHALL control divide-by-zero bypass.
REQ-037 With DIV_SHARE_ZERO_CHECK_EN defined, a granted divisor of 0 SHALL skip ISSUE and WAIT (IDLE -> RESP) with no div_start, and respond with quotient=all ones, remainder=dividend, err=1.
REQ-038 Without DIV_SHARE_ZERO_CHECK_EN, a zero divisor SHALL be issued to the divider like any other operand, and err SHALL be set only by timeout.

Verification
REQ-039 Single op: req=01, dividend0=100, divisor0=7 -> one div_start pulse; resp_valid=01 one cycle; quotient=14, remainder=2, err=0.
REQ-040 Contention: req=11 after reset (pointer=0) -> requester 0 served first, then requester 1; with both held high, grants alternate 0,1,0,1.
REQ-041 Done masking: a previous op leaves div_done=1 -> a new grant still waits for a fresh done; no response appears one cycle after ISSUE.
REQ-042 Timeout: a divider model that never raises done, WAIT_MAX=10 -> resp_valid pulses 10 cycles after entering WAIT with err=1, quotient=0 and remainder=0.
REQ-043 Zero divisor, macro defined: dividend1=55, divisor1=0 -> no div_start; resp_valid=10; quotient=8'hFF, remainder=55, err=1.
REQ-044 Zero divisor, macro undefined: the same stimulus as REQ-043 -> div_start is issued.
REQ-045 Reset mid-WAIT: rst=1 for one cycle -> busy=0 and no resp_valid; a following req=10 is served normally.
